// File: rtl/instr_seq_ctrl_if.sv
// Handshake/control bundle between the sequencing FSM (master) and the fetch/register/ALU/memory datapath (slave).
interface instr_seq_ctrl_if #(
  parameter int INSTR_W = 24,
  parameter int IMM_W   = 8
);
  logic [INSTR_W-1:0] Instr;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               PCSrc;
  logic [IMM_W-1:0]   immediate;
  logic [1:0]         alu_op;
  logic               alu_src_imm;
  logic               reg_we;
  logic [3:0]         rd;
  logic [3:0]         rs;
  logic [3:0]         rt;
  logic               mem_re;
  logic               mem_we;
  logic               halted;
  logic [1:0]         err;

  modport master (
    input  Instr, zero, mem_ready,
    output pc_en, PCSrc, immediate, alu_op, alu_src_imm, reg_we,
           rd, rs, rt, mem_re, mem_we, halted, err
  );

  modport slave (
    output Instr, zero, mem_ready,
    input  pc_en, PCSrc, immediate, alu_op, alu_src_imm, reg_we,
           rd, rs, rt, mem_re, mem_we, halted, err
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; control outputs are combinational from state and ir.
// Optional PERF_CNT_EN adds retired_cnt (wrapping) and stall_cnt (saturating) counters.
module instr_seq_ctrl #(
  parameter int INSTR_W     = 24,
  parameter int IMM_W       = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  instr_seq_ctrl_if.master   bus
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         err_q, err_d;
  logic [3:0]         opcode;

  logic       pc_en, pc_src, alu_src_imm, reg_we, mem_re, mem_we, halted;
  logic [1:0] alu_op;

  assign opcode = ir_q[INSTR_W-1 -: 4];

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    alu_op      = 2'b00;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = bus.Instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode > OP_HALT) begin
          err_d[0] = 1'b1;
          state_d  = S_HALT;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD:  state_d = S_WB;
          OP_SUB: begin
            alu_op  = 2'b01;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_op      = 2'b10;
            alu_src_imm = 1'b1;
            state_d     = S_WB;
          end
          OP_LD, OP_ST: begin
            cnt_d   = '0;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            pc_en   = 1'b1;
            pc_src  = bus.zero;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_en   = 1'b1;
            pc_src  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_re = (opcode == OP_LD);
        mem_we = (opcode == OP_ST);
        // A late mem_ready on the final allowed cycle still completes the access.
        if (bus.mem_ready) begin
          if (opcode == OP_LD) begin
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d[1] = 1'b1;
          state_d  = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.PCSrc       = pc_src;
  assign bus.immediate   = ir_q[IMM_W-1:0];
  assign bus.alu_op      = alu_op;
  assign bus.alu_src_imm = alu_src_imm;
  assign bus.reg_we      = reg_we;
  assign bus.rd          = ir_q[19:16];
  assign bus.rs          = ir_q[15:12];
  assign bus.rt          = ir_q[11:8];
  assign bus.mem_re      = mem_re;
  assign bus.mem_we      = mem_we;
  assign bus.halted      = halted;
  assign bus.err         = err_q;

`ifdef PERF_CNT_EN
  logic [15:0] retired_cnt_q, retired_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (pc_en) retired_cnt_d = retired_cnt_q + 16'd1;
    if (state_q == S_MEM && !bus.mem_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl: table of single-instruction runs plus halt/timeout/reset sequences.
module tb_instr_seq_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  instr_seq_ctrl_if #(.INSTR_W(24), .IMM_W(8)) bus ();

`ifdef PERF_CNT_EN
  logic [15:0] retired_cnt;
  logic [15:0] stall_cnt;
  instr_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus),
                      .retired_cnt(retired_cnt), .stall_cnt(stall_cnt));
`else
  instr_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] ins;
    logic        z;
    int          dly;
    int          cyc;
    logic        pcsrc;
    logic [7:0]  imm;
    int          regwe;
    logic [3:0]  rd;
    logic [1:0]  aluop;
    logic        alusrc;
    int          memcyc;
  } vec_t;

  vec_t vt[12];

  int         r_pc_cyc, r_pc_cnt, r_regwe_cnt, r_memcyc, r_halt_cyc;
  logic       r_pcsrc, r_alusrc;
  logic [7:0] r_imm;
  logic [3:0] r_rd;
  logic [1:0] r_aluop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a negedge with the FSM in FETCH; returns at the negedge that starts the next cycle.
  task automatic run_instr(input logic [23:0] ins, input logic z, input int dly, input int max_cyc);
    r_pc_cyc = 0; r_pc_cnt = 0; r_regwe_cnt = 0; r_memcyc = 0; r_halt_cyc = 0;
    r_pcsrc = 1'b0; r_imm = 8'h00; r_rd = 4'h0; r_aluop = 2'b00; r_alusrc = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      bus.Instr     = ins;
      bus.zero      = z;
      bus.mem_ready = (c >= 4 + dly);
      #1;
      if (c == 3) begin
        r_aluop  = bus.alu_op;
        r_alusrc = bus.alu_src_imm;
      end
      if (bus.mem_re || bus.mem_we) r_memcyc++;
      if (bus.reg_we) r_regwe_cnt++;
      if (bus.halted && r_halt_cyc == 0) r_halt_cyc = c;
      if (bus.pc_en) begin
        if (r_pc_cyc == 0) begin
          r_pc_cyc = c;
          r_pcsrc  = bus.PCSrc;
          r_imm    = bus.immediate;
          r_rd     = bus.rd;
        end
        r_pc_cnt++;
      end
      @(negedge clk);
      if (r_pc_cnt != 0) break;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.Instr = 24'h0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    vt[0]  = '{24'h000000, 1'b0, 0,  3, 1'b0, 8'h00, 0, 4'h0, 2'b00, 1'b0, 0};
    vt[1]  = '{24'h312005, 1'b0, 0,  4, 1'b0, 8'h05, 1, 4'h1, 2'b10, 1'b1, 0};
    vt[2]  = '{24'h600007, 1'b1, 0,  3, 1'b1, 8'h07, 0, 4'h0, 2'b00, 1'b0, 0};
    vt[3]  = '{24'h600007, 1'b0, 0,  3, 1'b0, 8'h07, 0, 4'h0, 2'b00, 1'b0, 0};
    vt[4]  = '{24'h430000, 1'b0, 3,  8, 1'b0, 8'h00, 1, 4'h3, 2'b00, 1'b0, 4};
    vt[5]  = '{24'h1123AB, 1'b0, 0,  4, 1'b0, 8'hAB, 1, 4'h1, 2'b00, 1'b0, 0};
    vt[6]  = '{24'h2456CD, 1'b1, 0,  4, 1'b0, 8'hCD, 1, 4'h4, 2'b01, 1'b0, 0};
    vt[7]  = '{24'h7000F0, 1'b0, 0,  3, 1'b1, 8'hF0, 0, 4'h0, 2'b00, 1'b0, 0};
    vt[8]  = '{24'h500011, 1'b0, 0,  4, 1'b0, 8'h11, 0, 4'h0, 2'b00, 1'b0, 1};
    vt[9]  = '{24'h500011, 1'b0, 2,  6, 1'b0, 8'h11, 0, 4'h0, 2'b00, 1'b0, 3};
    vt[10] = '{24'h420000, 1'b0, 0,  5, 1'b0, 8'h00, 1, 4'h2, 2'b00, 1'b0, 1};
    vt[11] = '{24'h4E0000, 1'b0, 14, 19, 1'b0, 8'h00, 1, 4'hE, 2'b00, 1'b0, 15};

    // Reset state while reset is held low.
    @(negedge clk);
    #1;
    check("reset outputs",
          {bus.pc_en, bus.PCSrc, bus.reg_we, bus.mem_re, bus.mem_we, bus.halted,
           bus.alu_src_imm, bus.alu_op, bus.err, bus.immediate},
          32'h0);
    check("reset regs", {bus.rd, bus.rs, bus.rt}, 32'h0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_instr(vt[i].ins, vt[i].z, vt[i].dly, 25);
      check($sformatf("v%0d pc_cycle", i), r_pc_cyc, vt[i].cyc);
      check($sformatf("v%0d pcsrc", i), r_pcsrc, vt[i].pcsrc);
      check($sformatf("v%0d imm", i), r_imm, vt[i].imm);
      check($sformatf("v%0d reg_we_cnt", i), r_regwe_cnt, vt[i].regwe);
      check($sformatf("v%0d rd", i), r_rd, vt[i].rd);
      check($sformatf("v%0d alu_op", i), r_aluop, vt[i].aluop);
      check($sformatf("v%0d alu_src_imm", i), r_alusrc, vt[i].alusrc);
      check($sformatf("v%0d mem_cycles", i), r_memcyc, vt[i].memcyc);
    end
    check("err clean after table", bus.err, 2'b00);

    // ST with mem_ready stuck low: 15 MEM cycles, then bus-error halt.
    run_instr(24'h500000, 1'b0, 1000, 22);
    check("st_to pc_en count", r_pc_cnt, 0);
    check("st_to mem cycles", r_memcyc, 15);
    check("st_to halt cycle", r_halt_cyc, 19);
    check("st_to err", bus.err, 2'b10);
    check("st_to halted", bus.halted, 1'b1);

    do_reset();
    run_instr(24'hA00000, 1'b0, 0, 6);
    check("illegal halt cycle", r_halt_cyc, 3);
    check("illegal err", bus.err, 2'b01);
    check("illegal pc_en count", r_pc_cnt, 0);

    do_reset();
    check("err cleared by reset", bus.err, 2'b00);
    run_instr(24'h800000, 1'b0, 0, 6);
    check("halt op cycle", r_halt_cyc, 3);
    check("halt op err", bus.err, 2'b00);
    check("halt op pc_en count", r_pc_cnt, 0);

    // Reset asserted while an LD is waiting in MEM.
    do_reset();
    run_instr(24'h430000, 1'b0, 1000, 5);
    bus.mem_ready = 1'b0;
    #1;
    check("mid mem_re before reset", bus.mem_re, 1'b1);
    reset = 1'b0;
    #1;
    check("mid reset outputs",
          {bus.pc_en, bus.reg_we, bus.mem_re, bus.mem_we, bus.halted, bus.err, bus.rd},
          32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      run_instr(24'h000000, 1'b0, 0, 8);
      check($sformatf("post reset nop%0d cycle", n), r_pc_cyc, 3);
    end
`ifdef PERF_CNT_EN
    check("retired_cnt", retired_cnt, 16'd3);
    check("stall_cnt", stall_cnt, 16'd0);
    run_instr(24'h430000, 1'b0, 3, 12);
    check("retired_cnt after ld", retired_cnt, 16'd4);
    check("stall_cnt after ld", stall_cnt, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
Multi-cycle control FSM that sequences the instruction-memory/PC datapath. Latches each 24-bit instruction and decodes it. Drives PC advance/branch selection (pc_en, PCSrc, immediate) plus register, ALU and data-memory control, so each instruction takes 3-5+ cycles. Sits between the fetch datapath and the register file/ALU/data memory.

Parameters:
INSTR_W, 24, instruction width; opcode [23:20], rd [19:16], rs [15:12], rt [11:8], imm [7:0]
IMM_W, 8, branch/immediate width driven to the PC block
MEM_TIMEOUT, 15, maximum MEM-state cycles waiting for mem_ready before a bus error

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Instr  input  INSTR_W  instruction from instruction memory at the current PC
zero  input  1  ALU zero flag, valid in EXEC
mem_ready  input  1  data-memory completion handshake
pc_en  output  1  PC update strobe; PC loads on the rising edge where pc_en=1
PCSrc  output  1  1 = branch (PC+immediate), 0 = PC+1
immediate  output  IMM_W  branch offset or ALU immediate (ir[7:0])
alu_op  output  2  00 add, 01 sub, 10 pass-immediate, 11 reserved
alu_src_imm  output  1  ALU B operand = immediate
reg_we  output  1  register-file write strobe
rd, rs, rt  output  4 each  register indices from ir
mem_re, mem_we  output  1 each  data-memory read/write request
halted  output  1  FSM in HALT
err  output  2  sticky: bit0 illegal opcode, bit1 memory timeout

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH; ir=0; all strobes=0; PCSrc=0; immediate=0; halted=0; err=0; timeout counter=0.
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 ADDI
  - 4 LD
  - 5 ST
  - 6 BEQ (taken if zero=1)
  - 7 JMP
  - 8 HALT
  - 9-15 illegal
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: ir <= Instr at the cycle's rising edge exit; always goes to DECODE.
- DECODE: rd/rs/rt/immediate come from ir (registered, stable until the next FETCH).
  - Illegal opcode: err[0]<=1, go to HALT.
  - HALT opcode: go to HALT.
  - All others: go to EXEC.
- EXEC behaviour by opcode:
  - ADD/SUB/ADDI: alu_op/alu_src_imm asserted; go to WB.
  - LD/ST: go to MEM; counter cleared.
  - NOP: pc_en=1, PCSrc=0; go to FETCH.
  - BEQ: pc_en=1, PCSrc=zero; go to FETCH.
  - JMP: pc_en=1, PCSrc=1; go to FETCH.
- MEM: mem_re (LD) or mem_we (ST) held high while waiting; counter increments each cycle mem_ready=0.
  - mem_ready=1 on LD: go to WB.
  - mem_ready=1 on ST: pc_en=1 in this same cycle, PCSrc=0; go to FETCH.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0: err[1]<=1, go to HALT, no pc_en.
  - mem_ready=1 in the same cycle the counter hits MEM_TIMEOUT: completion wins.
- WB: reg_we=1 and pc_en=1, PCSrc=0, for exactly one cycle; go to FETCH.
- Latency: NOP/BEQ/JMP 3 cycles; ALU ops 4; ST 4+waits; LD 5+waits.
- pc_en is high for exactly one cycle per retired instruction and never in FETCH, DECODE or HALT.
- PCSrc and immediate are meaningful only while pc_en=1; PCSrc=0 in all other cycles.
- HALT: halted=1, all strobes 0; left only by reset.
- err bits are cleared only by reset.
- Reset asserted mid-instruction: outputs drop immediately (asynchronous); no partial reg_we or pc_en completes.
- Control outputs are combinational from state and ir; state and counter are registered.

Optional Feature:
PERF_CNT_EN
- Defined:
  - Adds output retired_cnt (16 bits), incremented on every pc_en cycle; wraps 0xFFFF->0.
  - Adds output stall_cnt (16 bits), incremented on every MEM cycle with mem_ready=0; saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: neither port exists; no counter logic is built.

Test Plan:
1. Reset low, then release; Instr=0x000000 (NOP) -> FETCH/DECODE/EXEC sequence; pc_en=1, PCSrc=0 on cycle 3 only; no reg_we.
2. Instr=0x312005 (ADDI rd=1 rs=2 imm=5) -> alu_src_imm=1, alu_op=10 in EXEC; reg_we=1, rd=1, pc_en=1 in cycle 4.
3. Instr=0x600007 (BEQ, imm=7) with zero=1 -> cycle 3: pc_en=1, PCSrc=1, immediate=0x07. Repeat with zero=0 -> PCSrc=0.
4. Instr=0x430000 (LD) with mem_ready low for 3 cycles -> mem_re held 4 MEM cycles; WB reg_we=1; total 8 cycles.
5. Instr=0x500000 (ST) with mem_ready held 0 -> after 15 MEM cycles err=10, halted=1, pc_en never asserted. Instr=0xA00000 -> err=01, halted=1 after DECODE.
6. Reset pulsed low during MEM of an LD -> all outputs 0 immediately, state FETCH. With PERF_CNT_EN, after 3 NOPs retired_cnt=3.
